// File: rtl/pic_pkg.sv
// Shared definitions for the panel input conditioner: button FSM encoding
// and default debounce constants.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } btn_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned CNT_W_DEF           = 19;
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned NUM_SW              = 7;

endpackage

// File: rtl/debounce_cell.sv
// Single-bit synchroniser plus stability counter: the output follows the
// synchronised input only after it has differed for DEBOUNCE_CYCLES cycles.
module debounce_cell
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   din_s;

  assign din_s = sync_q[SYNC_STAGES-1];

  // Any match with the current output restarts the window.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d  = '0;
    dout_d = dout_q;
    if (din_s != dout_q) begin
      if (cnt_q >= CNT_LAST) begin
        dout_d = din_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/panel_input_conditioner.sv
// Cleans raw board inputs for the coffee-machine FSM: debounced switches,
// registered VL match flag, and a debounced A button with a one-cycle press pulse.
module panel_input_conditioner
  import pic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter bit          A_ACTIVE_LOW    = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SR,
  input  logic SP,
  input  logic SN,
  input  logic V0,
  input  logic V1,
  input  logic B0,
  input  logic B1,
  input  logic A,
  output logic SR_S,
  output logic SP_S,
  output logic SN_S,
  output logic V0_S,
  output logic V1_S,
  output logic B0_S,
  output logic B1_S,
  output logic VL,
  output logic A_LVL,
  output logic A_PULSE
);

  // Button transitions fire as the counter reaches DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [NUM_SW-1:0] sw_raw, sw_deb;

  assign sw_raw = {B1, B0, V1, V0, SN, SP, SR};

  for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
    debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk  (CLK),
      .rst_n(RST_N),
      .din  (sw_raw[i]),
      .dout (sw_deb[i])
    );
  end

  assign SR_S = sw_deb[0];
  assign SP_S = sw_deb[1];
  assign SN_S = sw_deb[2];
  assign V0_S = sw_deb[3];
  assign V1_S = sw_deb[4];
  assign B0_S = sw_deb[5];
  assign B1_S = sw_deb[6];

  logic vl_q, vl_d;

  assign vl_d = (sw_deb[4] == sw_deb[6]) && (sw_deb[3] == sw_deb[5]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) vl_q <= 1'b0;
    else        vl_q <= vl_d;
  end

  assign VL = vl_q;

  // Button synchroniser resets to the idle pin level so reset release never looks like a press.
  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic                   a_p;

  assign a_sync_d = {a_sync_q[SYNC_STAGES-2:0], A};
  assign a_p      = a_sync_q[SYNC_STAGES-1] ^ A_ACTIVE_LOW;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) a_sync_q <= {SYNC_STAGES{A_ACTIVE_LOW}};
    else        a_sync_q <= a_sync_d;
  end

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_lvl_q, a_lvl_d;
  logic             a_pulse_q, a_pulse_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_lvl_q   <= 1'b0;
      a_pulse_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_lvl_q   <= a_lvl_d;
      a_pulse_q <= a_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (a_p) begin
          state_d = ARMING;
          cnt_d   = '0;
        end
      end
      ARMING: begin
        if (!a_p) begin
          state_d = IDLE;
        end else if (cnt_q >= CNT_PRE) begin
          state_d = PRESSED;
          cnt_d   = CNT_LAST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!a_p) begin
          state_d = RELEASING;
          cnt_d   = '0;
        end
      end
      RELEASING: begin
        if (a_p) begin
          state_d = PRESSED;
        end else if (cnt_q >= CNT_PRE) begin
          state_d = IDLE;
          cnt_d   = CNT_LAST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Only the ARMING->PRESSED edge pulses; RELEASING->PRESSED is a bounce.
  always_comb begin
    a_pulse_d = 1'b0;
    a_lvl_d   = 1'b0;
    if (state_q == ARMING && state_d == PRESSED) a_pulse_d = 1'b1;
    if (state_d == PRESSED || state_d == RELEASING) a_lvl_d = 1'b1;
  end

  assign A_LVL   = a_lvl_q;
  assign A_PULSE = a_pulse_q;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Scoreboard bench for panel_input_conditioner: a sliding-window reference
// model predicts every output each cycle; a monitor compares independently.
module tb_panel_input_conditioner;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SYNC = 2;

  logic CLK, RST_N;
  logic SR, SP, SN, V0, V1, B0, B1, A;
  logic SR_S, SP_S, SN_S, V0_S, V1_S, B0_S, B1_S, VL, A_LVL, A_PULSE;
  logic [9:0] outs;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  logic [9:0] sb[$];

  // Model state: raw history through the synchroniser, last DEB synced samples, levels.
  bit [7:0] rawh [SYNC];
  bit [7:0] win  [DEB];
  bit [7:0] lvl;

  panel_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .SYNC_STAGES    (SYNC),
    .A_ACTIVE_LOW   (1'b1)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .SR     (SR),
    .SP     (SP),
    .SN     (SN),
    .V0     (V0),
    .V1     (V1),
    .B0     (B0),
    .B1     (B1),
    .A      (A),
    .SR_S   (SR_S),
    .SP_S   (SP_S),
    .SN_S   (SN_S),
    .V0_S   (V0_S),
    .V1_S   (V1_S),
    .B0_S   (B0_S),
    .B1_S   (B1_S),
    .VL     (VL),
    .A_LVL  (A_LVL),
    .A_PULSE(A_PULSE)
  );

  assign outs = {A_PULSE, A_LVL, VL, B1_S, B0_S, V1_S, V0_S, SN_S, SP_S, SR_S};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
  endtask

  function automatic void model_reset();
    foreach (rawh[j]) rawh[j] = '0;
    foreach (win[j]) win[j] = '0;
    lvl = '0;
  endfunction

  // A level flips once the last DEB synchronised samples all disagree with it.
  function automatic logic [9:0] model_step(input bit [7:0] lv);
    bit [7:0] nxt;
    bit       vl_e;
    bit       flip;
    vl_e = (lvl[4] == lvl[6]) && (lvl[3] == lvl[5]);
    for (int j = DEB - 1; j > 0; j--) win[j] = win[j-1];
    win[0] = rawh[SYNC-1];
    for (int j = SYNC - 1; j > 0; j--) rawh[j] = rawh[j-1];
    rawh[0] = lv;
    nxt = lvl;
    for (int b = 0; b < 8; b++) begin
      flip = 1'b1;
      for (int j = 0; j < DEB; j++) if (win[j][b] == lvl[b]) flip = 1'b0;
      if (flip) nxt[b] = ~lvl[b];
    end
    model_step = {nxt[7] & ~lvl[7], nxt[7], vl_e, nxt[6:0]};
    lvl = nxt;
  endfunction

  // lv = {a_pressed, B1, B0, V1, V0, SN, SP, SR}; A pin is active-low.
  task automatic drive(input bit [7:0] lv);
    {B1, B0, V1, V0, SN, SP, SR} = lv[6:0];
    A = ~lv[7];
  endtask

  task automatic cycle(input bit [7:0] lv);
    logic [9:0] e;
    drive(lv);
    @(posedge CLK);
    #1;
    e = model_step(lv);
    sb.push_back(e);
    if (A_PULSE) pulses++;
  endtask

  task automatic hold(input bit [7:0] lv, input int n);
    repeat (n) cycle(lv);
  endtask

  task automatic do_reset(input bit [7:0] lv, input int n);
    RST_N = 1'b0;
    sb.delete();
    drive(lv);
    #1;
    check("reset_outputs_zero", 32'(outs), 32'd0);
    repeat (n) @(posedge CLK);
    #1;
    check("reset_held_zero", 32'(outs), 32'd0);
    model_reset();
    RST_N = 1'b1;
  endtask

  initial begin : monitor
    logic [9:0] exp_v;
    forever begin
      @(negedge CLK);
      if (sb.size() != 0) begin
        exp_v = sb.pop_front();
        check("scoreboard_outputs", 32'(outs), 32'(exp_v));
      end
    end
  end

  initial begin : stim
    bit [7:0] lv;
    RST_N = 1'b1;
    drive(8'h00);
    #1;

    // Reset with A held and V=01: pulse and V0_S exactly after the window.
    lv = 8'b1000_1000;
    do_reset(lv, 3);
    pulses = 0;
    hold(lv, 10);
    check("t1_pulse_count", 32'(pulses), 32'd1);
    check("t1_v0_s", 32'(V0_S), 32'd1);
    check("t1_a_lvl", 32'(A_LVL), 32'd1);

    // Clean press and release timing.
    lv[7] = 1'b0;
    hold(lv, 10);
    check("t2_idle_lvl", 32'(A_LVL), 32'd0);
    pulses = 0;
    lv[7] = 1'b1;
    hold(lv, 20);
    check("t2_pulse_count", 32'(pulses), 32'd1);
    lv[7] = 1'b0;
    hold(lv, 5);
    check("t2_lvl_before_window", 32'(A_LVL), 32'd1);
    hold(lv, 1);
    check("t2_lvl_after_window", 32'(A_LVL), 32'd0);
    hold(lv, 4);

    // Bouncy press.
    pulses = 0;
    lv[7] = 1'b1; cycle(lv);
    lv[7] = 1'b0; cycle(lv);
    lv[7] = 1'b1; cycle(lv);
    lv[7] = 1'b0; cycle(lv);
    lv[7] = 1'b1; hold(lv, 10);
    check("t3_pulse_count", 32'(pulses), 32'd1);
    lv[7] = 1'b0; hold(lv, 10);

    // Release bounce while pressed.
    pulses = 0;
    lv[7] = 1'b1; hold(lv, 10);
    lv[7] = 1'b0; hold(lv, 2);
    lv[7] = 1'b1; hold(lv, 10);
    check("t4_pulse_count", 32'(pulses), 32'd1);
    check("t4_lvl_held", 32'(A_LVL), 32'd1);
    lv[7] = 1'b0; hold(lv, 10);

    // Switch glitch shorter than the window, then a real change.
    lv[1] = 1'b1; hold(lv, 3);
    lv[1] = 1'b0; hold(lv, 8);
    check("t5_glitch_rejected", 32'(SP_S), 32'd0);
    lv[1] = 1'b1; hold(lv, 5);
    check("t5_sp_before_window", 32'(SP_S), 32'd0);
    hold(lv, 1);
    check("t5_sp_after_window", 32'(SP_S), 32'd1);

    // VL match, then mismatch after B0 changes.
    lv[3] = 1'b0; lv[4] = 1'b1; lv[5] = 1'b0; lv[6] = 1'b1;
    hold(lv, 8);
    check("t6_vl_match", 32'(VL), 32'd1);
    lv[5] = 1'b1;
    hold(lv, 6);
    check("t6_vl_before", 32'(VL), 32'd1);
    hold(lv, 1);
    check("t6_vl_after", 32'(VL), 32'd0);

    // Reset in the middle of a debounce count.
    lv[0] = 1'b1; hold(lv, 3);
    do_reset(lv, 2);
    hold(lv, 10);
    check("t6_sr_after_reset", 32'(SR_S), 32'd1);

    // Randomised slow-toggling inputs with occasional resets.
    lv = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if (c == 1000 || c == 2000) do_reset(lv, int'($urandom_range(1, 4)));
      for (int b = 0; b < 8; b++) if ($urandom_range(5) == 0) lv[b] = ~lv[b];
      cycle(lv);
    end

    @(negedge CLK);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
